msg_echo: RTL and testbench

Message-level echo engine on the user side of the AXI portal. It consumes request words from the portal's `write$enq` stream, frames them as header-plus-payload messages, and buffers each payload. It then replays each message as an indication on the portal's `read$enq` stream, so software bring-up can round-trip messages through the portal with no user logic behind it.

---
 rtl/msg_pkg.sv | 22 ++
 rtl/msg_echo_buf.sv | 71 +++++++
 rtl/msg_echo.sv | 171 +++++++++++++++++
 tb/tb_msg_echo.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msg_pkg
// Brief    : Shared types and header field constants for the msg_echo engine.
// Revision : 1.0 - initial release
// ============================================================================
package msg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_DROP      = 3'd2,
        ST_EMIT_HDR  = 3'd3,
        ST_EMIT_DATA = 3'd4
    } state_t;

    localparam int          MID_LSB     = 16;
    localparam int          COUNT_WIDTH = 16;
    localparam logic [15:0] ERR_MID     = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/msg_echo_buf.sv
`default_nettype none
// ============================================================================
// Module   : msg_echo_buf
// Brief    : DEPTH x 32 synchronous FIFO with flush and a registered head word.
// Revision : 1.0 - initial release
// ============================================================================
module msg_echo_buf #(
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    input  logic                     push,
    input  logic [31:0]              push_data,
    input  logic                     pop,
    output logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        w_full, w_empty, w_do_push, w_do_pop;

    assign w_empty   = (wr_ptr_q == rd_ptr_q);
    assign w_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_do_push = push && !w_full && !flush;
    assign w_do_pop  = pop && !w_empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Bypass the word being written when it becomes the new head.
        if (w_do_push && (rd_ptr_d == wr_ptr_q))
            rd_data_d = push_data;
        else
            rd_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end

    always_ff @(posedge CLK) begin
        if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign count   = wr_ptr_q - rd_ptr_q;

endmodule
`default_nettype wire

// File: rtl/msg_echo.sv
`default_nettype none
// ============================================================================
// Module   : msg_echo
// Brief    : Frames portal request words into messages and echoes them back as
//            indications. Optional trailing checksum word: MSG_ECHO_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module msg_echo
    import msg_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        write_enq__ENA,
    input  logic [31:0] write_enq_v,
    input  logic [15:0] write_enq_length,
    output logic        write_enq__RDY,
    output logic        read_enq__ENA,
    output logic [31:0] read_enq_v,
    output logic [15:0] read_enq_length,
    input  logic        read_enq__RDY
);

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] hdr_q, hdr_d;
    logic [15:0] len_q, len_d;
`ifdef MSG_ECHO_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    logic                    w_emit, w_xfer, w_acc;
    logic [15:0]             w_n, w_mid, w_nout;
    logic                    w_push, w_pop, w_flush;
    logic [31:0]             w_buf_data;
    logic [$clog2(DEPTH):0]  w_buf_count;
    logic                    unused_sink;

    assign w_emit = (state_q == ST_EMIT_HDR) || (state_q == ST_EMIT_DATA);
    assign w_xfer = nRST && w_emit && read_enq__RDY;
    assign w_acc  = write_enq__ENA && write_enq__RDY;
    assign w_n    = write_enq_v[COUNT_WIDTH-1:0];
    assign w_mid  = write_enq_v[31:MID_LSB];
`ifdef MSG_ECHO_CHECKSUM_EN
    assign w_nout      = w_n + 16'd1;
    assign unused_sink = ^{write_enq_length};
`else
    assign w_nout      = w_n;
    assign unused_sink = ^{write_enq_length, w_buf_count};
`endif

    assign w_push  = w_acc && (state_q == ST_COLLECT);
    assign w_pop   = w_xfer && (state_q == ST_EMIT_DATA);
    assign w_flush = w_acc && (state_q == ST_IDLE);

    msg_echo_buf #(.DEPTH(DEPTH)) u_buf (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (w_flush),
        .push      (w_push),
        .push_data (write_enq_v),
        .pop       (w_pop),
        .rd_data   (w_buf_data),
        .count     (w_buf_count)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        hdr_d   = hdr_q;
        len_d   = len_q;
`ifdef MSG_ECHO_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            ST_IDLE: if (w_acc) begin
                hdr_d = {w_mid + 16'd1, w_nout};
                len_d = w_nout + 16'd1;
`ifdef MSG_ECHO_CHECKSUM_EN
                sum_d = '0;
`endif
                if (w_n == 16'd0) begin
                    state_d = ST_EMIT_HDR;
                end else if (w_n > DEPTH_W) begin
                    state_d = ST_DROP;
                    cnt_d   = w_n;
                    err_d   = 1'b1;
                    hdr_d   = {ERR_MID, 16'd0};
                    len_d   = 16'd1;
                end else begin
                    state_d = ST_COLLECT;
                    cnt_d   = w_n;
                end
            end
            ST_COLLECT: if (w_acc) begin
                cnt_d = cnt_q - 16'd1;
`ifdef MSG_ECHO_CHECKSUM_EN
                sum_d = sum_q + write_enq_v;
`endif
                if (cnt_q == 16'd1) state_d = ST_EMIT_HDR;
            end
            ST_DROP: if (w_acc) begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) state_d = ST_EMIT_HDR;
            end
            ST_EMIT_HDR: if (w_xfer) begin
                len_d = len_q - 16'd1;
                if (len_q == 16'd1) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_EMIT_DATA;
                end
            end
            ST_EMIT_DATA: if (w_xfer) begin
                len_d = len_q - 16'd1;
                if (len_q == 16'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            hdr_q   <= '0;
            len_q   <= '0;
`ifdef MSG_ECHO_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            hdr_q   <= hdr_d;
            len_q   <= len_d;
`ifdef MSG_ECHO_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Outputs are forced low while reset is held, independent of the state flop.
    always_comb begin
        write_enq__RDY  = nRST && (state_q == ST_IDLE || state_q == ST_COLLECT ||
                                   state_q == ST_DROP);
        read_enq__ENA   = w_xfer;
        read_enq_v      = '0;
        read_enq_length = '0;
        if (nRST && w_emit) begin
            read_enq_length = len_q;
            if (state_q == ST_EMIT_HDR)
                read_enq_v = hdr_q;
            else
`ifdef MSG_ECHO_CHECKSUM_EN
                read_enq_v = (w_buf_count == '0) ? sum_q : w_buf_data;
`else
                read_enq_v = w_buf_data;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msg_echo.sv
`default_nettype none
// ============================================================================
// Module   : tb_msg_echo
// Brief    : Self-checking bench for msg_echo against a message-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msg_echo;

    localparam int          DEPTH   = 16;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);
`ifdef MSG_ECHO_CHECKSUM_EN
    localparam logic [15:0] CK = 16'd1;
`else
    localparam logic [15:0] CK = 16'd0;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        wr_ena = 1'b0;
    logic [31:0] wr_v = '0;
    logic [15:0] wr_len = '0;
    logic        wr_rdy;
    logic        rd_ena;
    logic [31:0] rd_v;
    logic [15:0] rd_len;
    logic        rd_rdy = 1'b1;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    logic [31:0] pl_q[$];
    logic [47:0] exp_q[$];
    logic [47:0] got_q[$];
    int unsigned got_cyc[$];

    always #5 CLK = ~CLK;

    msg_echo #(.DEPTH(DEPTH)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .write_enq__ENA   (wr_ena),
        .write_enq_v      (wr_v),
        .write_enq_length (wr_len),
        .write_enq__RDY   (wr_rdy),
        .read_enq__ENA    (rd_ena),
        .read_enq_v       (rd_v),
        .read_enq_length  (rd_len),
        .read_enq__RDY    (rd_rdy)
    );

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (rd_ena === 1'b1) begin
            got_q.push_back({rd_v, rd_len});
            got_cyc.push_back(cyc);
        end
    end

    // Expected indication stream for header hdr and payload pl_q.
    function automatic void build_exp(input logic [31:0] hdr);
        logic [15:0] n;
        logic [15:0] nout;
        logic [31:0] sum;
        n   = hdr[15:0];
        sum = '0;
        exp_q.delete();
        if (n > DEPTH16) begin
            exp_q.push_back({32'hFFFF_0000, 16'd1});
            return;
        end
        nout = n + CK;
        exp_q.push_back({hdr[31:16] + 16'd1, nout, nout + 16'd1});
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({pl_q[i], nout - 16'(i)});
            sum = sum + pl_q[i];
        end
        if (CK != 16'd0) exp_q.push_back({sum, 16'd1});
    endfunction

    task automatic send_word(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wr_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        if (!ok) return;
        wr_ena = 1'b1;
        wr_v   = w;
        wr_len = 16'($urandom);
        @(posedge CLK); #1;
        wr_ena = 1'b0;
        wr_v   = $urandom;
    endtask

    task automatic send_msg(input logic [31:0] hdr, input int gap_max, output bit ok);
        bit w_ok;
        send_word(hdr, ok);
        foreach (pl_q[i]) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge CLK); #1;
            end
            send_word(pl_q[i], w_ok);
            ok = ok & w_ok;
        end
    endtask

    task automatic drain(input bit rand_rdy, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (got_q.size() >= exp_q.size()) begin
                ok = 1'b1;
                break;
            end
            rd_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge CLK); #1;
        end
        rd_rdy = 1'b1;
    endtask

    task automatic start_case();
        got_q.delete();
        got_cyc.delete();
        pl_q.delete();
        rd_rdy = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (wr_rdy !== 1'b0 || rd_ena !== 1'b0 || rd_v !== 32'd0 || rd_len !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b ena=%b v=%h len=%h required 0 0 0 0",
                     wr_rdy, rd_ena, rd_v, rd_len);
        end
        nRST = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (wr_rdy !== 1'b1 || rd_ena !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got rdy=%b ena=%b required 1 0", wr_rdy, rd_ena);
        end
    endtask

    task automatic test_basic();
        bit ok, d_ok;
        start_case();
        pl_q = '{32'h11, 32'h22, 32'h33};
        build_exp(32'h0005_0003);
        send_msg(32'h0005_0003, 0, ok);
        checks++;
        if (rd_ena !== 1'b1 || {rd_v, rd_len} !== exp_q[0]) begin
            errors++;
            $display("FAIL basic_hdr_latency got ena=%b %h required 1 %h", rd_ena, {rd_v, rd_len}, exp_q[0]);
        end
        drain(1'b0, d_ok);
        checks++;
        if (!ok || !d_ok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count got %0d words (ok=%b/%b) required %0d", got_q.size(), ok, d_ok, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_word%0d got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_q.size() == 0 || got_cyc[got_cyc.size()-1] - got_cyc[0] != got_q.size() - 1) begin
            errors++;
            $display("FAIL basic_back_to_back got span %0d required %0d",
                     got_q.size() == 0 ? 0 : got_cyc[got_cyc.size()-1] - got_cyc[0], got_q.size() - 1);
        end
        checks++;
        if (wr_rdy !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle got rdy=%b required 1", wr_rdy);
        end
    endtask

    task automatic test_zero();
        bit ok, d_ok;
        start_case();
        build_exp(32'h0007_0000);
        send_msg(32'h0007_0000, 0, ok);
        drain(1'b0, d_ok);
        checks++;
        if (!ok || !d_ok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL zero_count got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL zero_word%0d got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (wr_rdy !== 1'b1) begin
            errors++;
            $display("FAIL zero_idle got rdy=%b required 1", wr_rdy);
        end
    endtask

    task automatic test_drop();
        bit ok, d_ok;
        start_case();
        for (int i = 0; i < 20; i++) pl_q.push_back($urandom);
        build_exp(32'h0001_0014);
        send_msg(32'h0001_0014, 1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drop_accept got ok=%b required 1", ok);
        end
        drain(1'b0, d_ok);
        checks++;
        if (!d_ok || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL drop_indication got %0d words first %h required 1 word %h",
                     got_q.size(), got_q.size() ? got_q[0] : 48'h0, exp_q[0]);
        end
        checks++;
        if (wr_rdy !== 1'b1) begin
            errors++;
            $display("FAIL drop_idle got rdy=%b required 1", wr_rdy);
        end
    endtask

    task automatic test_backpressure();
        bit ok, d_ok;
        bit ena_seen, moved, rdy_seen;
        logic [31:0] sv;
        logic [15:0] sl;
        start_case();
        for (int i = 0; i < 4; i++) pl_q.push_back($urandom);
        build_exp(32'h0009_0004);
        send_msg(32'h0009_0004, 0, ok);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        rd_rdy = 1'b0;
        sv = rd_v;
        sl = rd_len;
        ena_seen = 1'b0; moved = 1'b0; rdy_seen = 1'b0;
        repeat (10) begin
            @(posedge CLK); #1;
            ena_seen |= (rd_ena !== 1'b0);
            moved    |= (rd_v !== sv) || (rd_len !== sl);
            rdy_seen |= (wr_rdy !== 1'b0);
        end
        checks++;
        if ({sv, sl} !== exp_q[2]) begin
            errors++;
            $display("FAIL bp_held_word got %h required %h", {sv, sl}, exp_q[2]);
        end
        checks++;
        if (ena_seen || moved || rdy_seen) begin
            errors++;
            $display("FAIL bp_stall got ena=%b moved=%b wrdy=%b required 0 0 0", ena_seen, moved, rdy_seen);
        end
        drain(1'b0, d_ok);
        checks++;
        if (!ok || !d_ok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_count got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_word%0d got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, d_ok, bad;
        start_case();
        send_word(32'h0004_0003, ok);
        send_word(32'hDEAD_0001, ok);
        send_word(32'hDEAD_0002, ok);
        nRST = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            #1;
            bad |= (wr_rdy !== 1'b0) || (rd_ena !== 1'b0) || (rd_v !== 32'd0) || (rd_len !== 16'd0);
            @(posedge CLK); #1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midreset_outputs got nonzero output during reset required all 0");
        end
        nRST = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_abandon got %0d words required 0", got_q.size());
        end
        pl_q = '{32'hAA};
        build_exp(32'h0002_0001);
        send_msg(32'h0002_0001, 0, ok);
        drain(1'b0, d_ok);
        checks++;
        if (!ok || !d_ok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midreset_count got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midreset_word%0d got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_mid_wrap();
        bit ok, d_ok;
        start_case();
        pl_q = '{32'h5};
        build_exp(32'hFFFE_0001);
        send_msg(32'hFFFE_0001, 0, ok);
        drain(1'b0, d_ok);
        checks++;
        if (!ok || !d_ok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL wrap_count got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_word%0d got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok, d_ok;
        logic [31:0] hdr;
        for (int m = 0; m < 40; m++) begin
            start_case();
            hdr = {16'($urandom), 16'($urandom_range(0, DEPTH + 3))};
            for (int i = 0; i < int'(hdr[15:0]); i++) pl_q.push_back($urandom);
            build_exp(hdr);
            send_msg(hdr, 2, ok);
            drain(1'b1, d_ok);
            checks++;
            if (!ok || !d_ok || got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count hdr %h got %0d words required %0d", m, hdr, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d got %h required %h", m, i, got_q[i], exp_q[i]);
                end
            end
            checks++;
            if (wr_rdy !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_idle got rdy=%b required 1", m, wr_rdy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_drop();
        test_backpressure();
        test_reset_mid();
        test_mid_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
